debug_unit: RTL

Command controller sitting directly downstream of the UART receiver and upstream of its transmitter. It consumes received bytes (`rx_data`/`rx_data_rdy`), interprets them as single-byte debug commands, and gates the MIPS core via a clock enable and a reset pulse. It serialises core state (PC, registers) read through a debug read port back to the host through `w_data`/`write_enable`.

---
 rtl/debug_pkg.sv | 41 ++++
 rtl/debug_unit_if.sv | 32 +++
 rtl/debug_tx_sender.sv | 35 +++
 rtl/debug_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the debug command controller: command bytes,
// handshake reply bytes, FSM state encoding and a word-to-byte helper.
// No ports; imported by debug_unit and debug_tx_sender.
package debug_pkg;

  // Single-byte host commands
  localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
  localparam logic [7:0] CMD_CONT = 8'h63;  // 'c'
  localparam logic [7:0] CMD_HALT = 8'h68;  // 'h'
  localparam logic [7:0] CMD_RST  = 8'h72;  // 'r'
  localparam logic [7:0] CMD_DUMP = 8'h64;  // 'd'

  // Reply bytes
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP,
    ST_RUN,
    ST_RESET,
    ST_FETCH,
    ST_SEND,
    ST_ACK
  } state_t;

  // Byte idx of a 32-bit word, MSB first (idx 0 -> [31:24]).
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      2'd0: b = w[31:24];
      2'd1: b = w[23:16];
      2'd2: b = w[15:8];
      2'd3: b = w[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/debug_unit_if.sv
// Bundle of the debug controller's UART-side and core-side signals.
// master: the debug_unit (drives w_data/write_enable/cpu_enable/cpu_reset/dbg_addr).
// slave:  the environment (UART + core) driving rx_data/rx_data_rdy/tx_full/cpu_halted/dbg_data.
interface debug_unit_if #(
  parameter int ADDR_W = 6
);

  // UART receive side
  logic [7:0]        rx_data;
  logic              rx_data_rdy;
  // UART transmit side
  logic              tx_full;
  logic [7:0]        w_data;
  logic              write_enable;
  // Core control and debug read port
  logic              cpu_enable;
  logic              cpu_reset;
  logic              cpu_halted;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_data;

  modport master (
    input  rx_data, rx_data_rdy, tx_full, cpu_halted, dbg_data,
    output w_data, write_enable, cpu_enable, cpu_reset, dbg_addr
  );

  modport slave (
    output rx_data, rx_data_rdy, tx_full, cpu_halted, dbg_data,
    input  w_data, write_enable, cpu_enable, cpu_reset, dbg_addr
  );

endinterface

// File: rtl/debug_tx_sender.sv
// Purpose: hands one byte at a time to the UART transmitter on request.
// Latency: request accepted in cycle X -> write_enable/w_data registered in X+1.
// Backpressure: holds off while tx_full=1; the requester keeps send/tx_byte
//   stable until the one-cycle 'sent' pulse, so no byte is lost.
// Ports: clk, rst (async active-high); send/tx_byte request in, sent pulse out;
//   tx_full in from the UART; w_data/write_enable registered out to the UART.
module debug_tx_sender (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] tx_byte,
  input  logic       tx_full,
  output logic       sent,
  output logic [7:0] w_data,
  output logic       write_enable
);

  // The write lands in the cycle after acceptance, so tx_full is checked in
  // the cycle preceding the write. Refusing while write_enable is high gives
  // the mandatory idle cycle after every write.
  assign sent = send && !tx_full && !write_enable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_data       <= 8'h00;
      write_enable <= 1'b0;
    end else begin
      write_enable <= sent;
      if (sent) begin
        w_data <= tx_byte;
      end
    end
  end

endmodule

// File: rtl/debug_unit.sv
// Purpose: decodes host debug command bytes; steps/runs/resets the core and
//   dumps PC + GPRs over the UART.
// Latency: command in cycle N -> cpu_enable/cpu_reset in N+1, ACK write in N+3,
//   dump dbg_addr=0 in N+1 and first byte in N+3.
// Backpressure: tx_full stalls the pending reply/dump byte in place; bytes
//   received outside IDLE are dropped (except 'h' while running).
// Ports: clk, rst (async active-high); bus (debug_unit_if.master) carrying the
//   UART rx/tx signals and the core's enable, reset, halted and debug read port.
module debug_unit
  import debug_pkg::*;
#(
  parameter int DUMP_WORDS = 33,
  parameter int ADDR_W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  debug_unit_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DUMP_WORDS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] word_cnt, word_cnt_nxt;
  logic [1:0]        byte_cnt, byte_cnt_nxt;
  logic [31:0]       word_reg, word_reg_nxt;
  logic [7:0]        resp, resp_nxt;
  logic              cpu_enable_q, cpu_enable_nxt;
  logic              cpu_reset_q, cpu_reset_nxt;

  logic              send;
  logic [7:0]        tx_byte;
  logic              sent;
  logic [7:0]        tx_w_data;
  logic              tx_write_enable;
  logic              halt_req;

  // Either the core halting on its own or the host asking for it ends a run;
  // both in the same cycle still count as one halt.
  assign halt_req = bus.cpu_halted || (bus.rx_data_rdy && (bus.rx_data == CMD_HALT));

  debug_tx_sender u_tx (
    .clk          (clk),
    .rst          (rst),
    .send         (send),
    .tx_byte      (tx_byte),
    .tx_full      (bus.tx_full),
    .sent         (sent),
    .w_data       (tx_w_data),
    .write_enable (tx_write_enable)
  );

  assign bus.w_data       = tx_w_data;
  assign bus.write_enable = tx_write_enable;
  assign bus.cpu_enable   = cpu_enable_q;
  assign bus.cpu_reset    = cpu_reset_q;
  // The word counter is itself a register, so it doubles as dbg_addr.
  assign bus.dbg_addr     = word_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      word_cnt     <= '0;
      byte_cnt     <= 2'd0;
      word_reg     <= 32'h0;
      resp         <= ACK;
      cpu_enable_q <= 1'b0;
      cpu_reset_q  <= 1'b0;
    end else begin
      state        <= state_nxt;
      word_cnt     <= word_cnt_nxt;
      byte_cnt     <= byte_cnt_nxt;
      word_reg     <= word_reg_nxt;
      resp         <= resp_nxt;
      cpu_enable_q <= cpu_enable_nxt;
      cpu_reset_q  <= cpu_reset_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    word_cnt_nxt   = word_cnt;
    byte_cnt_nxt   = byte_cnt;
    word_reg_nxt   = word_reg;
    resp_nxt       = resp;
    cpu_enable_nxt = 1'b0;
    cpu_reset_nxt  = 1'b0;
    send           = 1'b0;
    tx_byte        = resp;

    case (state)
      ST_IDLE: begin
        if (bus.rx_data_rdy) begin
          case (bus.rx_data)
            CMD_STEP: begin
              if (bus.cpu_halted) begin
                // A halted core cannot step: refuse without pulsing enable.
                resp_nxt  = NAK;
                state_nxt = ST_ACK;
              end else begin
                cpu_enable_nxt = 1'b1;
                state_nxt      = ST_STEP;
              end
            end
            CMD_CONT: begin
              if (bus.cpu_halted) begin
                resp_nxt  = ACK;
                state_nxt = ST_ACK;
              end else begin
                cpu_enable_nxt = 1'b1;
                state_nxt      = ST_RUN;
              end
            end
            CMD_RST: begin
              cpu_reset_nxt = 1'b1;
              state_nxt     = ST_RESET;
            end
            CMD_DUMP: begin
              word_cnt_nxt = '0;
              byte_cnt_nxt = 2'd0;
              state_nxt    = ST_FETCH;
            end
            default: begin
              resp_nxt  = NAK;
              state_nxt = ST_ACK;
            end
          endcase
        end
      end

      ST_STEP: begin
        // The one-cycle enable is already on the pins; default drops it.
        resp_nxt  = ACK;
        state_nxt = ST_ACK;
      end

      ST_RESET: begin
        resp_nxt  = ACK;
        state_nxt = ST_ACK;
      end

      ST_RUN: begin
        if (halt_req) begin
          resp_nxt  = ACK;
          state_nxt = ST_ACK;
        end else begin
          cpu_enable_nxt = 1'b1;
        end
      end

      ST_FETCH: begin
        // dbg_data is a combinational read of the word at dbg_addr.
        word_reg_nxt = bus.dbg_data;
        byte_cnt_nxt = 2'd0;
        state_nxt    = ST_SEND;
      end

      ST_SEND: begin
        send    = 1'b1;
        tx_byte = word_byte(word_reg, byte_cnt);
        if (sent) begin
          byte_cnt_nxt = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            if (word_cnt == LAST_WORD) begin
              // A dump ends silently: the data itself is the reply.
              state_nxt = ST_IDLE;
            end else begin
              word_cnt_nxt = word_cnt + ADDR_W'(1);
              state_nxt    = ST_FETCH;
            end
          end
        end
      end

      // Sends whichever reply byte was chosen on entry (ACK or NAK).
      ST_ACK: begin
        send    = 1'b1;
        tx_byte = resp;
        if (sent) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
